// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared definitions for the SPI-attached RAM controller.
//   CMD_W / DATA_W : command word width from the SPI slave, RAM data width
//   CMD_*          : opcode values carried in din[9:8]
//   state_t        : controller FSM state encoding
package spi_ram_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    TX_BUSY = 2'd2
  } state_t;

endpackage

// File: rtl/sp_ram_array.sv
// sp_ram_array: plain synchronous single-port RAM with a registered read.
// Contents are never reset.
//   clk   in   : clock, write and read both on rising edge
//   we    in   : write enable, writes wdata to mem[addr]
//   addr  in   : shared read/write address
//   wdata in   : write data
//   rdata out  : mem[addr] as it was before this edge's write
module sp_ram_array #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command decoder + RAM sitting behind the SPI slave.
// Each rx_valid strobe executes din as a command ([9:8] opcode, [7:0]
// payload). A read returns data on dout with tx_valid held for TX_HOLD
// cycles so the slave can shift it out.
//   clk      in  : system clock
//   rst      in  : asynchronous, active-high reset
//   din      in  : 10-bit command word
//   rx_valid in  : single-cycle strobe qualifying din
//   dout     out : read data, holds its last value while tx_valid=0
//   tx_valid out : dout valid, high for TX_HOLD cycles per read
// Optional feature macro: RAM_ADDR_AUTOINC_EN (post-increment wr_addr on
// each WR_DATA and rd_addr after each FETCH, wrapping MEM_DEPTH-1 -> 0).
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid
);

  localparam int unsigned DEPTH_U = MEM_DEPTH;
  localparam int          CNT_W   = $clog2(TX_HOLD);

  state_t               state, state_next;
  logic [CNT_W-1:0]     hold_cnt;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 rd_oob;

  logic [1:0]           opcode;
  logic [ADDR_SIZE-1:0] addr_payload;
  logic                 cmd_wr_addr, cmd_wr_data, cmd_rd_addr, cmd_rd_data;
  logic                 rd_accept;
  logic                 wr_in_range, rd_in_range;

  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_W-1:0]    mem_rdata;

  assign opcode       = din[9:8];
  assign addr_payload = din[ADDR_SIZE-1:0];

  assign cmd_wr_addr = rx_valid && (opcode == CMD_WR_ADDR);
  assign cmd_wr_data = rx_valid && (opcode == CMD_WR_DATA);
  assign cmd_rd_addr = rx_valid && (opcode == CMD_RD_ADDR);
  assign cmd_rd_data = rx_valid && (opcode == CMD_RD_DATA);

  // A read already in flight (FETCH) swallows further RD_DATA commands.
  assign rd_accept = cmd_rd_data && (state != FETCH);

  assign wr_in_range = (32'(wr_addr) < DEPTH_U);
  assign rd_in_range = (32'(rd_addr) < DEPTH_U);

  // The array read is issued on the accepting edge itself, so rdata is
  // ready during FETCH and the port is free for writes arriving in FETCH.
  // A WR_DATA one strobe earlier has already landed by then.
  assign mem_we   = cmd_wr_data && wr_in_range;
  assign mem_addr = rd_accept ? rd_addr : wr_addr;

  assign tx_valid = (state == TX_BUSY);

  sp_ram_array #(
    .DEPTH (MEM_DEPTH),
    .ADDR_W(ADDR_SIZE),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(din[DATA_W-1:0]),
    .rdata(mem_rdata)
  );

`ifdef RAM_ADDR_AUTOINC_EN
  // Wraps at MEM_DEPTH-1; out-of-range addresses just count on naturally.
  function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
    return (32'(a) == DEPTH_U - 1) ? '0 : a + ADDR_SIZE'(1);
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (rd_accept) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = TX_BUSY;
      end
      TX_BUSY: begin
        if (rd_accept) begin
          state_next = FETCH;
        end else if (hold_cnt == '0) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FETCH always reloads, so a restart gets a full fresh hold window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == FETCH) begin
      hold_cnt <= CNT_W'(TX_HOLD - 1);
    end else if ((state == TX_BUSY) && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_oob <= 1'b0;
      dout   <= '0;
    end else begin
      if (rd_accept) begin
        rd_oob <= !rd_in_range;
      end
      if (state == FETCH) begin
        dout <= rd_oob ? '0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
    end else if (cmd_wr_addr) begin
      wr_addr <= addr_payload;
    end
`ifdef RAM_ADDR_AUTOINC_EN
    else if (cmd_wr_data) begin
      wr_addr <= addr_inc(wr_addr);
    end
`endif
  end

  // An explicit RD_ADDR arriving during FETCH wins over the post-increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr <= '0;
    end else if (cmd_rd_addr) begin
      rd_addr <= addr_payload;
    end
`ifdef RAM_ADDR_AUTOINC_EN
    else if (state == FETCH) begin
      rd_addr <= addr_inc(rd_addr);
    end
`endif
  end

endmodule
